dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the datapath load/store path (CPU) and an external loader/debug port (EXT).
- Arbitrates round-robin and sequences a fixed-latency memory access, MEM_LAT cycles long.
- Returns read data with a one-cycle acknowledge.
- Drives cpu_stall so the datapath holds its PC until its own access completes.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter_rr_arbiter2.sv | 21 ++
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// requester ids and the saturating increment used by the optional perf counters.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_EXT = 1'b1;

  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX + 1);

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the view of the surrounding system.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_ack;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_ack, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_ack, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// requester that was not granted last.
module rr_arbiter2 (
  input  logic cpu_req_i,
  input  logic ext_req_i,
  input  logic last_grant_i,
  output logic gnt_vld_o,
  output logic gnt_id_o
);
  import dmem_arb_pkg::*;

  always_comb begin
    gnt_vld_o = cpu_req_i | ext_req_i;
    gnt_id_o  = REQ_CPU;
    if (cpu_req_i && ext_req_i) begin
      gnt_id_o = ~last_grant_i;
    end else if (ext_req_i) begin
      gnt_id_o = REQ_EXT;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares one fixed-latency data-memory port between the CPU and an EXT loader port.
// Define DMEM_ARB_PERF_EN to add saturating grant/stall performance counters.
module dmem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  dmem_arbiter_if.slave       bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_cpu_grants,
  output logic [31:0]         perf_ext_grants,
  output logic [31:0]         perf_stall_cycles
`endif
);
  import dmem_arb_pkg::*;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              gnt_id_q, gnt_id_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              pick_vld, pick_id;
  logic              cpu_stall;

  rr_arbiter2 u_rr (
    .cpu_req_i    (bus.cpu_req),
    .ext_req_i    (bus.ext_req),
    .last_grant_i (last_q),
    .gnt_vld_o    (pick_vld),
    .gnt_id_o     (pick_id)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    gnt_id_d    = gnt_id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_id_d = pick_id;
          last_d   = pick_id;
          we_d     = (pick_id == REQ_EXT) ? bus.ext_we    : bus.cpu_we;
          addr_d   = (pick_id == REQ_EXT) ? bus.ext_addr  : bus.cpu_addr;
          wdata_d  = (pick_id == REQ_EXT) ? bus.ext_wdata : bus.cpu_wdata;
          cnt_d    = CNT_W'(MEM_LAT - 1);
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        // Memory data is valid on the last access cycle; stores keep the old rdata.
        if (cnt_q == '0) begin
          if (!we_q && gnt_id_q == REQ_CPU) cpu_rdata_d = bus.mem_rdata;
          if (!we_q && gnt_id_q == REQ_EXT) ext_rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= REQ_EXT;
      gnt_id_q    <= REQ_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      gnt_id_q    <= gnt_id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

  // Strobes decode straight from the state register so reset drops them asynchronously.
  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_ack   = (state_q == RESP) & (gnt_id_q == REQ_CPU);
  assign bus.ext_ack   = (state_q == RESP) & (gnt_id_q == REQ_EXT);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ext_rdata = ext_rdata_q;
  assign cpu_stall     = bus.cpu_req & ~bus.cpu_ack;
  assign bus.cpu_stall = cpu_stall;

`ifdef DMEM_ARB_PERF_EN
  logic        grant;
  logic [31:0] cpu_grants_q, ext_grants_q, stall_cycles_q;

  assign grant = (state_q == IDLE) & pick_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_grants_q   <= '0;
      ext_grants_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (grant && pick_id == REQ_CPU) cpu_grants_q <= sat_inc32(cpu_grants_q);
      if (grant && pick_id == REQ_EXT) ext_grants_q <= sat_inc32(ext_grants_q);
      if (cpu_stall) stall_cycles_q <= sat_inc32(stall_cycles_q);
    end
  end

  assign perf_cpu_grants   = cpu_grants_q;
  assign perf_ext_grants   = ext_grants_q;
  assign perf_stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts each grant,
// its memory beats and its ack; a monitor pops and compares whenever the DUT acks.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int LAT = 2;
  localparam logic [63:0] L_RDATA = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus   ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1  ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus15 ();

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] pc_g, pe_g, ps_c, pc_g1, pe_g1, ps_c1, pc_g15, pe_g15, ps_c15;
`endif

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk (clk), .rst (rst), .bus (bus)
`ifdef DMEM_ARB_PERF_EN
    , .perf_cpu_grants (pc_g), .perf_ext_grants (pe_g), .perf_stall_cycles (ps_c)
`endif
  );
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut_l1 (
    .clk (clk), .rst (rst), .bus (bus1)
`ifdef DMEM_ARB_PERF_EN
    , .perf_cpu_grants (pc_g1), .perf_ext_grants (pe_g1), .perf_stall_cycles (ps_c1)
`endif
  );
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(15)) dut_l15 (
    .clk (clk), .rst (rst), .bus (bus15)
`ifdef DMEM_ARB_PERF_EN
    , .perf_cpu_grants (pc_g15), .perf_ext_grants (pe_g15), .perf_stall_cycles (ps_c15)
`endif
  );

  typedef struct {
    logic        id;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          g;
  } txn_t;

  typedef struct {
    logic        id;
    int          c;
    logic [63:0] rdata;
  } ack_t;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          n_acks = 0;
  int          beats = 0;
  int          exp_stall = 0;
  txn_t        exp_q[$];
  ack_t        ack_log[$];
  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] env_mem [logic [63:0]];
  logic        m_last;
  int          m_free;
  logic [63:0] m_rd [2];
  logic [63:0] held [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic logic [63:0] dflt(input logic [63:0] a);
    return a ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction

  // Reference model: one access at a time, MEM_LAT+2 cycles apart, ties alternate.
  initial begin : model
    txn_t e;
    forever begin
      @(posedge clk);
      if (!rst) begin
        exp_q.delete();
        m_last = REQ_EXT;
        m_free = 0;
        m_rd[0] = '0;
        m_rd[1] = '0;
      end else if (cyc >= m_free && (bus.cpu_req || bus.ext_req)) begin
        if (bus.cpu_req && bus.ext_req) e.id = ~m_last;
        else e.id = bus.ext_req;
        e.we    = e.id ? bus.ext_we    : bus.cpu_we;
        e.addr  = e.id ? bus.ext_addr  : bus.cpu_addr;
        e.wdata = e.id ? bus.ext_wdata : bus.cpu_wdata;
        e.g     = cyc;
        if (e.we) begin
          ref_mem[e.addr] = e.wdata;
          e.rdata = m_rd[e.id];
        end else begin
          e.rdata = ref_mem.exists(e.addr) ? ref_mem[e.addr] : dflt(e.addr);
          m_rd[e.id] = e.rdata;
        end
        exp_q.push_back(e);
        m_last = e.id;
        m_free = cyc + LAT + 2;
      end
      cyc++;
    end
  end

  // Memory behind the main DUT.
  initial begin : memory
    forever begin
      @(negedge clk);
      if (bus.mem_en && bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
      bus.mem_rdata = env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr] : dflt(bus.mem_addr);
    end
  end

  initial begin : monitor
    txn_t e;
    ack_t a;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        held[0] = '0;
        held[1] = '0;
        beats = 0;
      end else begin
        if (bus.mem_we) chk("mem_we_gated", 64'(bus.mem_en), 64'd1);
        if (bus.mem_en) begin
          if (exp_q.size() == 0) chk("mem_en_unexpected", 64'(bus.mem_en), 64'd0);
          else begin
            chk("mem_addr",  bus.mem_addr,  exp_q[0].addr);
            chk("mem_we",    64'(bus.mem_we), 64'(exp_q[0].we));
            chk("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
            beats++;
          end
        end
        if (bus.cpu_ack || bus.ext_ack) begin
          n_acks++;
          chk("single_ack", 64'(bus.cpu_ack & bus.ext_ack), 64'd0);
          if (exp_q.size() == 0) chk("ack_unexpected", 64'(bus.cpu_ack | bus.ext_ack), 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("ack_id", 64'(bus.ext_ack), 64'(e.id));
            chk("ack_cycle", 64'(cyc), 64'(e.g + LAT + 1));
            chk("mem_beats", 64'(beats), 64'(LAT));
            if (e.id) chk("ext_rdata", bus.ext_rdata, e.rdata);
            else      chk("cpu_rdata", bus.cpu_rdata, e.rdata);
            held[e.id] = e.rdata;
            a.id = bus.ext_ack; a.c = cyc; a.rdata = e.id ? bus.ext_rdata : bus.cpu_rdata;
            ack_log.push_back(a);
          end
          beats = 0;
        end else if (exp_q.size() > 0 && cyc > exp_q[0].g + LAT + 1) begin
          chk("ack_timeout", 64'(cyc), 64'(exp_q[0].g + LAT + 1));
          void'(exp_q.pop_front());
          beats = 0;
        end
        if (!bus.cpu_ack) chk("cpu_rdata_hold", bus.cpu_rdata, held[0]);
        if (!bus.ext_ack) chk("ext_rdata_hold", bus.ext_rdata, held[1]);
      end
    end
  end

  initial begin : stall_mon
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        chk("cpu_stall", 64'(bus.cpu_stall), 64'(bus.cpu_req & ~bus.cpu_ack));
        if (bus.cpu_req && !bus.cpu_ack) exp_stall++;
      end else exp_stall = 0;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic txn(input logic id, input logic we, input logic [63:0] addr,
                     input logic [63:0] wdata, input int gap);
    int t;
    repeat (gap + 1) @(negedge clk);
    if (id) begin
      bus.ext_we = we; bus.ext_addr = addr; bus.ext_wdata = wdata; bus.ext_req = 1'b1;
    end else begin
      bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(id ? bus.ext_ack : bus.cpu_ack) && t < 100);
    chk(id ? "ext_ack_wait" : "cpu_ack_wait", 64'(id ? bus.ext_ack : bus.cpu_ack), 64'd1);
    if (id) bus.ext_req = 1'b0;
    else    bus.cpu_req = 1'b0;
  endtask

  initial begin : main
    int start, acks_before, a1, a15, e1, e15, n1, n15;
    logic [63:0] r1, r15;
    int exp_rel[4];
    logic exp_id[4];
    exp_rel = '{3, 7, 11, 15};
    exp_id  = '{REQ_CPU, REQ_EXT, REQ_CPU, REQ_EXT};

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = '0; bus.ext_wdata = '0;
    bus.mem_rdata = '0;
    bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.ext_req = 0; bus1.ext_we = 0; bus1.ext_addr = '0; bus1.ext_wdata = '0;
    bus1.mem_rdata = L_RDATA;
    bus15.cpu_req = 0; bus15.cpu_we = 0; bus15.cpu_addr = '0; bus15.cpu_wdata = '0;
    bus15.ext_req = 0; bus15.ext_we = 0; bus15.ext_addr = '0; bus15.ext_wdata = '0;
    bus15.mem_rdata = ~L_RDATA;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_mem_en",    64'(bus.mem_en), 64'd0);
    chk("rst_mem_we",    64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr",  bus.mem_addr,  64'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
    chk("rst_cpu_ack",   64'(bus.cpu_ack), 64'd0);
    chk("rst_ext_ack",   64'(bus.ext_ack), 64'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 64'd0);
    chk("rst_ext_rdata", bus.ext_rdata, 64'd0);
    chk("rst_cpu_stall", 64'(bus.cpu_stall), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Both sides held from reset: strict alternation starting with the CPU.
    @(posedge clk); #1;
    start = cyc;
    ack_log.delete();
    fork
      begin
        txn(REQ_CPU, 1'b0, 64'h100, 64'h0, 0);
        txn(REQ_CPU, 1'b0, 64'h108, 64'h0, 0);
      end
      begin
        txn(REQ_EXT, 1'b1, 64'h200, 64'hAAAA_0001, 0);
        txn(REQ_EXT, 1'b1, 64'h208, 64'hAAAA_0002, 0);
      end
    join
    chk("alt_ack_count", 64'(ack_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      chk("alt_ack_id",  64'(ack_log[i].id), 64'(exp_id[i]));
      chk("alt_ack_rel", 64'(ack_log[i].c - start), 64'(exp_rel[i]));
    end
`ifdef DMEM_ARB_PERF_EN
    @(posedge clk); #1;
    chk("perf_cpu_grants",   64'(pc_g), 64'd2);
    chk("perf_ext_grants",   64'(pe_g), 64'd2);
    chk("perf_stall_cycles", 64'(ps_c), 64'(exp_stall));
`endif

    // Single CPU load from a preset location.
    env_mem[64'h40] = 64'hDEAD_BEEF;
    ref_mem[64'h40] = 64'hDEAD_BEEF;
    repeat (2) @(posedge clk); #1;
    start = cyc;
    ack_log.delete();
    txn(REQ_CPU, 1'b0, 64'h40, 64'h0, 0);
    chk("load_ack_count", 64'(ack_log.size()), 64'd1);
    if (ack_log.size() > 0) begin
      chk("load_ack_rel", 64'(ack_log[0].c - start), 64'd3);
      chk("load_rdata",   ack_log[0].rdata, 64'hDEAD_BEEF);
    end

    // EXT store.
    repeat (2) @(posedge clk); #1;
    start = cyc;
    ack_log.delete();
    txn(REQ_EXT, 1'b1, 64'h8, 64'h1234, 0);
    chk("store_ack_count", 64'(ack_log.size()), 64'd1);
    if (ack_log.size() > 0) begin
      chk("store_ack_id",  64'(ack_log[0].id), 64'(REQ_EXT));
      chk("store_ack_rel", 64'(ack_log[0].c - start), 64'd3);
    end

    // Randomized traffic from both sides over a small address set.
    fork
      begin
        for (int i = 0; i < 25; i++)
          txn(REQ_CPU, 1'($urandom_range(0, 1)), 64'($urandom_range(0, 7)) << 3,
              {$urandom, $urandom}, int'($urandom_range(0, 3)));
      end
      begin
        for (int j = 0; j < 25; j++)
          txn(REQ_EXT, 1'($urandom_range(0, 1)), 64'($urandom_range(0, 7)) << 3,
              {$urandom, $urandom}, int'($urandom_range(0, 3)));
      end
    join

    // Reset in the second access cycle: strobes drop at once and no ack follows.
    repeat (2) @(negedge clk);
    bus.cpu_we = 1'b0; bus.cpu_addr = 64'h10; bus.cpu_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_mem_en", 64'(bus.mem_en), 64'd1);
    acks_before = n_acks;
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    chk("async_mem_en", 64'(bus.mem_en), 64'd0);
    chk("async_mem_we", 64'(bus.mem_we), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_ack_after_rst", 64'(n_acks), 64'(acks_before));
    ack_log.delete();
    fork
      txn(REQ_CPU, 1'b0, 64'h18, 64'h0, 0);
      txn(REQ_EXT, 1'b0, 64'h20, 64'h0, 0);
    join
    chk("post_rst_ack_count", 64'(ack_log.size()), 64'd2);
    if (ack_log.size() > 1) begin
      chk("post_rst_first", 64'(ack_log[0].id), 64'(REQ_CPU));
      chk("post_rst_second", 64'(ack_log[1].id), 64'(REQ_EXT));
    end

    // MEM_LAT = 1 and MEM_LAT = 15 instances, one CPU load each.
    @(negedge clk);
    bus1.cpu_addr = 64'h20;  bus1.cpu_req = 1'b1;
    bus15.cpu_addr = 64'h20; bus15.cpu_req = 1'b1;
    a1 = 0; a15 = 0; e1 = 0; e15 = 0; n1 = 0; n15 = 0; r1 = '0; r15 = '0;
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk); #1;
      if (bus1.mem_en) e1++;
      if (bus15.mem_en) e15++;
      if (bus1.cpu_ack) begin
        n1++;
        if (a1 == 0) begin a1 = t; r1 = bus1.cpu_rdata; end
        bus1.cpu_req = 1'b0;
      end
      if (bus15.cpu_ack) begin
        n15++;
        if (a15 == 0) begin a15 = t; r15 = bus15.cpu_rdata; end
        bus15.cpu_req = 1'b0;
      end
    end
    chk("lat1_ack_cycle",  64'(a1), 64'd2);
    chk("lat1_mem_en",     64'(e1), 64'd1);
    chk("lat1_acks",       64'(n1), 64'd1);
    chk("lat1_rdata",      r1, L_RDATA);
    chk("lat15_ack_cycle", 64'(a15), 64'd16);
    chk("lat15_mem_en",    64'(e15), 64'd15);
    chk("lat15_acks",      64'(n15), 64'd1);
    chk("lat15_rdata",     r15, ~L_RDATA);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
